// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and constants for the mm:ss stopwatch counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  // Width of the seconds and minutes counts (enough for 0..59)
  localparam int CNT_W = 6;

  // Highest displayed value of each field before it rolls over
  localparam logic [CNT_W-1:0] MAX_SEC = 6'd59;
  localparam logic [CNT_W-1:0] MAX_MIN = 6'd59;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage : stopwatch_pkg

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module      : tick_gen
// Description : Prescaler counting 0..TICK_DIV-1 while enabled; flags the
//               cycle in which the count wraps (one counted second is due).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int                 c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TICK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_last;

  // Due flag: enabled and sitting on the final count of the second
  assign w_last = (r_cnt == c_LAST);
  assign tick   = enable & w_last;

  // Prescaler register: zeroed by clear, holds when disabled so the
  // fraction of a second survives a pause
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : (r_cnt + c_ONE);
    end
  end

endmodule : tick_gen

`default_nettype wire

// File: rtl/stopwatch_counter.sv
// ============================================================================
// Module      : stopwatch_counter
// Description : Start/stop/clear stopwatch producing binary seconds and
//               minutes (00:00..59:59) with tick and rollover pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ   = 100000000,
  parameter int TICK_DIV = CLK_HZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic [CNT_W-1:0] seconds,
  output logic [CNT_W-1:0] minutes,
  output logic             running,
  output logic             tick,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_in_run;
  logic             w_presc_en;
  logic             w_presc_clr;
  logic             w_due;
  logic             w_sec_last;
  logic             w_min_last;
  logic [CNT_W-1:0] r_sec;
  logic [CNT_W-1:0] r_min;
  logic             r_tick;
  logic             r_wrap;

  assign w_in_run = (r_state == RUN);

  // A clear arriving in RUN must suppress the tick due on that same edge,
  // so it gates the prescaler enable as well as zeroing it
  assign w_presc_en  = w_in_run & ~clear;
  assign w_presc_clr = clear | (r_state == IDLE);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (w_presc_en),
    .clear  (w_presc_clr),
    .tick   (w_due)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: clear beats stop beats start; stop outside RUN swallows a
  // simultaneous start
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else if (stop) begin
      if (r_state == RUN) begin
        w_state_nxt = PAUSE;
      end
    end else if (start) begin
      if ((r_state == IDLE) || (r_state == PAUSE)) begin
        w_state_nxt = RUN;
      end
    end
  end

  // Rollover points; >= keeps the fields inside 0..59 even from a bad value
  assign w_sec_last = (r_sec >= MAX_SEC);
  assign w_min_last = (r_min >= MAX_MIN);

  // Seconds/minutes counters plus registered tick and wrap pulses, all
  // updating on the same edge so new value and pulse appear together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec  <= '0;
      r_min  <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_tick <= w_due;
      r_wrap <= w_due & w_sec_last & w_min_last;
      if (clear) begin
        r_sec <= '0;
        r_min <= '0;
      end else if (w_due) begin
        if (w_sec_last) begin
          r_sec <= '0;
          r_min <= w_min_last ? '0 : (r_min + c_ONE);
        end else begin
          r_sec <= r_sec + c_ONE;
        end
      end
    end
  end

  assign seconds = r_sec;
  assign minutes = r_min;
  assign running = w_in_run;
  assign tick    = r_tick;
  assign wrap    = r_wrap;

endmodule : stopwatch_counter

`default_nettype wire

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, giving the input clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_DIV, default CLK_HZ, giving clock cycles per counted second; it SHALL be at least 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: synchronous pulse, already debounced, that begins or resumes counting.
REQ-006 Port stop, input, 1 bit: synchronous pulse that pauses counting.
REQ-007 Port clear, input, 1 bit: synchronous pulse that zeroes the count and returns to idle.
REQ-008 Port seconds, output, 6 bits: binary seconds 0..59, feeding the two-digit seconds display decoder.
REQ-009 Port minutes, output, 6 bits: binary minutes 0..59, feeding the minutes display decoder.
REQ-010 Port running, output, 1 bit: high while in state RUN.
REQ-011 Port tick, output, 1 bit: one-cycle pulse on each counted second.
REQ-012 Port wrap, output, 1 bit: one-cycle pulse when the count rolls over from 59:59 to 00:00.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and PAUSE.
REQ-014 FSM transitions SHALL be as follows:
- IDLE to RUN on start.
- RUN to PAUSE on stop.
- PAUSE to RUN on start.
- Any state to IDLE on clear.
- Otherwise the state holds.
REQ-015 Simultaneous inputs SHALL resolve with priority clear > stop > start; start and stop together in IDLE or PAUSE SHALL leave the state unchanged.
REQ-016 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, and SHALL wrap to 0 with tick=1 in the cycle its value is TICK_DIV-1.
REQ-017 The prescaler SHALL hold its value in PAUSE, so the fraction of a second is retained; it SHALL be zeroed in IDLE and on clear.
REQ-018 The prescaler width SHALL be $clog2(TICK_DIV).
REQ-019 seconds and minutes SHALL be registered; they update on the same clock edge that registers tick=1, so the new value and tick are visible together.
REQ-020 On tick, seconds SHALL increment; 59 SHALL wrap to 0 and increment minutes.
REQ-021 On tick at 59:59, seconds and minutes SHALL both become 0, wrap SHALL pulse for one cycle, and RUN SHALL continue.
REQ-022 seconds and minutes SHALL never leave 0..59 under any input sequence.
REQ-023 clear in RUN SHALL take effect at the next edge and suppress any tick and increment due on that edge.
REQ-024 stop asserted in the same cycle as a due tick SHALL let that tick and increment complete, then enter PAUSE.
REQ-025 start while already in RUN, and stop in IDLE or PAUSE, SHALL have no effect.

Reset
REQ-026 Asserting reset SHALL immediately force: state IDLE, prescaler 0, seconds 0, minutes 0, running 0, tick 0, wrap 0.
REQ-027 Reset asserted mid-count SHALL discard the count; after release the block SHALL wait for start.
REQ-028 Reset release SHALL be synchronised externally; the block SHALL NOT contain a reset synchroniser.

Structure
REQ-029 Package stopwatch_pkg SHALL hold:
- the state enum (IDLE, RUN, PAUSE);
- constant MAX_SEC = 59;
- constant MAX_MIN = 59;
- the 6-bit count width constant.
REQ-030 The prescaler SHALL be a sub-module named tick_gen, with ports clk, reset, enable, clear and tick, parameterised by TICK_DIV.
REQ-031 The FSM and the seconds/minutes counters SHALL reside in stopwatch_counter.

Verification
REQ-032 With TICK_DIV=4, reset, then start for 1 cycle -> running=1 next cycle; tick every 4 cycles; seconds=1 after 4 cycles, seconds=3 after 12 cycles.
REQ-033 Preload to 00:59 via counting, next tick -> seconds=0, minutes=1, wrap=0.
REQ-034 Count to 59:59, next tick -> 00:00, wrap=1 for exactly 1 cycle, running stays 1.
REQ-035 stop after 2 prescaler cycles, wait 10 cycles, then start -> seconds unchanged during pause; next tick 2 cycles after resume.
REQ-036 clear and start in the same cycle while in RUN at 00:07 -> IDLE, 00:00, running=0; also stop in the same cycle as a due tick -> increment taken, then PAUSE.
REQ-037 reset pulsed asynchronously between clock edges at 03:25 -> outputs 0 immediately, IDLE retained after release until start.
